// File: rtl/ins_arb_pkg.sv
// Shared constants and helpers for the instruction-memory arbiter.
// Optional build macro INS_ARB_MERGE_EN is consumed by ins_mem_arbiter.
package ins_arb_pkg;

    localparam int unsigned NUM_CORES_DEF  = 4;
    localparam int unsigned ADDR_WIDTH_DEF = 8;
    localparam int unsigned INS_WIDTH_DEF  = 9;

    // Upper bounds for the generic slice helper below.
    localparam int unsigned MAX_BUS_W  = 1024;
    localparam int unsigned MAX_ADDR_W = 64;

    function automatic int unsigned clog2(input int unsigned n);
        int unsigned r;
        r = 0;
        for (int unsigned v = 1; v < n; v = v << 1) begin
            r++;
        end
        return r;
    endfunction

    function automatic logic [MAX_ADDR_W-1:0] addr_slice(input logic [MAX_BUS_W-1:0] flat,
                                                         input int unsigned idx,
                                                         input int unsigned aw);
        logic [MAX_BUS_W-1:0] sh;
        logic [MAX_BUS_W-1:0] mask;
        sh   = flat >> (idx * aw);
        mask = (MAX_BUS_W'(1) << aw) - MAX_BUS_W'(1);
        return MAX_ADDR_W'(sh & mask);
    endfunction

endpackage

// File: rtl/ins_mem_arbiter_if.sv
// Fetch/memory bundle between cores, arbiter and instruction memory.
// master = cores + memory side, slave = arbiter side.
interface ins_mem_arbiter_if
    import ins_arb_pkg::*;
#(
    parameter int unsigned NUM_CORES  = NUM_CORES_DEF,
    parameter int unsigned ADDR_WIDTH = ADDR_WIDTH_DEF,
    parameter int unsigned INS_WIDTH  = INS_WIDTH_DEF
);
    logic [NUM_CORES-1:0]            req;
    logic [NUM_CORES*ADDR_WIDTH-1:0] pc_addr;
    logic [NUM_CORES-1:0]            grant;
    logic [ADDR_WIDTH-1:0]           mem_addr;
    logic                            mem_rEn;
    logic [INS_WIDTH-1:0]            mem_instruction;
    logic [INS_WIDTH-1:0]            ins_out;
    logic [NUM_CORES-1:0]            ins_valid;

    modport master (
        output req, pc_addr, mem_instruction,
        input  grant, mem_addr, mem_rEn, ins_out, ins_valid
    );

    modport slave (
        input  req, pc_addr, mem_instruction,
        output grant, mem_addr, mem_rEn, ins_out, ins_valid
    );

endinterface

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: searches upward from the last winner, wrapping.
// Pointer resets to N-1 so requester 0 has first priority.
module rr_arbiter
    import ins_arb_pkg::*;
#(
    parameter int unsigned N = 4,
    localparam int unsigned IW = clog2(N)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [N-1:0]  req,
    input  logic          adv,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] grant_idx
);

    logic [IW-1:0] last_q;
    logic [IW-1:0] cidx;
    int unsigned   cand;
    logic          found;

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        cand      = 0;
        cidx      = '0;
        for (int unsigned i = 1; i <= N; i++) begin
            cand = (32'(last_q) + i) % N;
            cidx = IW'(cand);
            if (!found && req[cidx]) begin
                found     = 1'b1;
                grant_idx = cidx;
            end
        end
        if (found && !rst) begin
            grant[grant_idx] = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_q <= IW'(N - 1);
        end else if (adv) begin
            last_q <= grant_idx;
        end
    end

endmodule

// File: rtl/ins_mem_arbiter.sv
// Shares one synchronous-read instruction memory among NUM_CORES fetch ports.
// Define INS_ARB_MERGE_EN to co-grant cores fetching the winner's address.
module ins_mem_arbiter
    import ins_arb_pkg::*;
#(
    parameter int unsigned NUM_CORES  = NUM_CORES_DEF,
    parameter int unsigned ADDR_WIDTH = ADDR_WIDTH_DEF,
    parameter int unsigned INS_WIDTH  = INS_WIDTH_DEF
) (
    input logic               clk,
    input logic               rst,
    ins_mem_arbiter_if.slave  bus
);

    localparam int unsigned IW = clog2(NUM_CORES);

    logic [ADDR_WIDTH-1:0] core_addr [NUM_CORES];
    logic [NUM_CORES-1:0]  rr_grant;
    logic [IW-1:0]         rr_idx;
    logic [NUM_CORES-1:0]  grant_out;
    logic [NUM_CORES-1:0]  valid_q;
    logic [ADDR_WIDTH-1:0] mem_addr_c;
    logic                  any_live;

    assign any_live = (|bus.req) & ~rst;

    for (genvar g = 0; g < NUM_CORES; g++) begin : g_addr
        assign core_addr[g] =
            ADDR_WIDTH'(addr_slice(MAX_BUS_W'(bus.pc_addr), g, ADDR_WIDTH));
    end

    rr_arbiter #(
        .N (NUM_CORES)
    ) u_rr (
        .clk       (clk),
        .rst       (rst),
        .req       (bus.req),
        .adv       (any_live),
        .grant     (rr_grant),
        .grant_idx (rr_idx)
    );

    assign mem_addr_c = any_live ? core_addr[rr_idx] : '0;

    for (genvar g = 0; g < NUM_CORES; g++) begin : g_merge
`ifdef INS_ARB_MERGE_EN
        // Lock-step cores share the winner's read; pointer still follows rr_idx.
        assign grant_out[g] = rr_grant[g] |
                              (bus.req[g] & any_live & (core_addr[g] == mem_addr_c));
`else
        assign grant_out[g] = rr_grant[g];
`endif
    end

    // Registered valid lines up with the memory's one-cycle read latency.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= '0;
        end else begin
            valid_q <= grant_out;
        end
    end

    assign bus.grant     = grant_out;
    assign bus.mem_rEn   = any_live;
    assign bus.mem_addr  = mem_addr_c;
    assign bus.ins_out   = bus.mem_instruction;
    assign bus.ins_valid = valid_q;

endmodule

// File: tb/tb_ins_mem_arbiter.sv
// Bench for ins_mem_arbiter: directed steps followed by random traffic,
// checked against a cycle-level reference model of the arbitration rules.
module tb_ins_mem_arbiter;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    ins_mem_arbiter_if #(
        .NUM_CORES  (4),
        .ADDR_WIDTH (8),
        .INS_WIDTH  (9)
    ) bus ();

    ins_mem_arbiter #(
        .NUM_CORES  (4),
        .ADDR_WIDTH (8),
        .INS_WIDTH  (9)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Memory: mem[a] = a + 0x100, one cycle after read enable, else holds.
    logic [8:0] mem_q = '0;
    always @(posedge clk) begin
        if (bus.mem_rEn) mem_q <= 9'h100 + 9'(bus.mem_addr);
    end
    assign bus.mem_instruction = mem_q;

    int vectors     = 0;
    int miscompares = 0;

    // Reference model state
    int         m_last;
    logic [3:0] m_prev;
    logic [8:0] m_read;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] pc_of(input logic [31:0] pcs, input int i);
        return 8'((pcs >> (8 * i)) & 32'hff);
    endfunction

    function automatic logic [31:0] pack(input logic [7:0] a0, input logic [7:0] a1,
                                         input logic [7:0] a2, input logic [7:0] a3);
        return {a3, a2, a1, a0};
    endfunction

    // First requester after the last winner, going around the ring.
    function automatic int rr_pick(input logic [3:0] r, input int last);
        for (int k = 1; k <= 4; k++) begin
            if (((r >> ((last + k) % 4)) & 4'd1) != 4'd0) return (last + k) % 4;
        end
        return -1;
    endfunction

    function automatic logic [3:0] model_grant(input logic [3:0] r, input logic [31:0] pcs,
                                               input int w);
        logic [3:0] g;
        if (w < 0) return 4'd0;
        g = 4'd1 << w;
`ifdef INS_ARB_MERGE_EN
        for (int i = 0; i < 4; i++) begin
            if (((r >> i) & 4'd1) != 4'd0 && pc_of(pcs, i) == pc_of(pcs, w)) g = g | (4'd1 << i);
        end
`endif
        return g;
    endfunction

    task automatic step(input logic [3:0] r, input logic [31:0] pcs);
        int         w;
        logic [3:0] g;
        logic [7:0] a;
        @(negedge clk);
        bus.req     = r;
        bus.pc_addr = pcs;
        #1;
        w = rr_pick(r, m_last);
        g = model_grant(r, pcs, w);
        a = (w < 0) ? 8'h00 : pc_of(pcs, w);
        check("grant", 32'(bus.grant), 32'(g));
        check("mem_rEn", 32'(bus.mem_rEn), 32'(r != 4'd0));
        check("mem_addr", 32'(bus.mem_addr), 32'(a));
        check("ins_valid", 32'(bus.ins_valid), 32'(m_prev));
        check("ins_out", 32'(bus.ins_out), 32'(m_read));
        if (w >= 0) begin
            m_last = w;
            m_read = 9'h100 + 9'(a);
        end
        m_prev = g;
    endtask

    initial begin
        bus.req     = 4'b1111;
        bus.pc_addr = pack(8'h00, 8'h10, 8'h20, 8'h30);
        m_last = 3;
        m_prev = 4'd0;
        m_read = 9'd0;

        // Reset forces grant and read enable low even with requests pending.
        #12;
        check("rst_grant", 32'(bus.grant), 32'd0);
        check("rst_rEn", 32'(bus.mem_rEn), 32'd0);
        check("rst_valid", 32'(bus.ins_valid), 32'd0);
        bus.req = 4'd0;
        @(negedge clk);
        rst = 1'b0;

        // Full rotation with all cores requesting
        for (int i = 0; i < 5; i++) step(4'b1111, pack(8'h00, 8'h10, 8'h20, 8'h30));

        // Single requester parks the pointer and is served back-to-back
        step(4'b0100, pack(8'h00, 8'h00, 8'h05, 8'h00));
        step(4'b0100, pack(8'h00, 8'h00, 8'h06, 8'h00));

        // Wrap from core 3 to core 0
        step(4'b1000, pack(8'h01, 8'h02, 8'h03, 8'h04));
        step(4'b1001, pack(8'h01, 8'h02, 8'h03, 8'h04));
        step(4'b1000, pack(8'h01, 8'h02, 8'h03, 8'h04));

        // Idle: memory output holds
        for (int i = 0; i < 3; i++) step(4'b0000, pack(8'h01, 8'h02, 8'h03, 8'h04));

        // Asynchronous reset one cycle after a grant to core 1
        step(4'b0010, pack(8'h00, 8'h5a, 8'h00, 8'h00));
        @(posedge clk);
        #1;
        check("pre_rst_valid", 32'(bus.ins_valid), 32'(m_prev));
        #1;
        rst = 1'b1;
        #1;
        check("async_rst_valid", 32'(bus.ins_valid), 32'd0);
        check("async_rst_grant", 32'(bus.grant), 32'd0);
        check("async_rst_rEn", 32'(bus.mem_rEn), 32'd0);
        m_last = 3;
        m_prev = 4'd0;
        @(negedge clk);
        @(negedge clk);
        bus.req = 4'd0;
        rst = 1'b0;
        step(4'b1111, pack(8'h00, 8'h10, 8'h20, 8'h30));
        step(4'b0000, pack(8'h00, 8'h10, 8'h20, 8'h30));

`ifdef INS_ARB_MERGE_EN
        step(4'b1111, pack(8'h44, 8'h44, 8'h44, 8'h44));
        step(4'b0000, pack(8'h44, 8'h44, 8'h44, 8'h44));
`endif

        // Random traffic; addresses from a small pool so equal PCs occur often
        for (int i = 0; i < 300; i++) begin
            logic [31:0] pcs;
            pcs = pack(8'($urandom_range(0, 3) * 17), 8'($urandom_range(0, 3) * 17),
                       8'($urandom_range(0, 3) * 17), 8'($urandom_range(0, 3) * 17));
            step(4'($urandom_range(0, 15)), pcs);
        end
        step(4'b0000, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
